id_stage_pipe: RTL and testbench
================================

// Module: id_stage_pipe
// PURPOSE
//   Pipelined instruction-decode stage for the RV32I core. It holds the register file (RF),
//   immediate sign-extension, write-back/EX operand forwarding and load-use hazard detection,
//   plus the ID/EX pipeline register with a valid/ready handshake. Sits between IF and EX.
//   The write-back select mux lives in WB; this block receives only the final wb_wd.
// PARAMETERS
//   XLEN     32  data and register width
//   NREG     32  number of architectural registers (index width AW = $clog2(NREG))
//   HAS_FWD  1   1: forward non-load EX results; 0: stall on any EX-destination match
// PORTS
//   clk            in   1     clock, posedge
//   rst            in   1     asynchronous reset, active-high
//   if_valid       in   1     IF presents a valid instruction
//   if_inst        in   32    instruction word
//   if_pc          in   XLEN  PC of if_inst
//   id_ready       out  1     ID accepts if_inst this cycle
//   sext_op        in   3     immediate type from control: 0 I, 1 S, 2 B, 3 U, 4 J, others -> 0
//   flush          in   1     kill the ID/EX contents (branch/jump redirect)
//   ex_ready       in   1     EX accepts the ID/EX register this cycle
//   ex_we          in   1     instruction currently in EX writes rd
//   ex_wr          in   AW    its rd
//   ex_wd          in   XLEN  its ALU result
//   ex_is_load     in   1     its result comes from DRAM (not yet available)
//   wb_we          in   1     RF write enable from WB
//   wb_wr          in   AW    RF write index
//   wb_wd          in   XLEN  RF write data
//   id_valid       out  1     ID/EX register holds a valid instruction
//   id_pc          out  XLEN  registered PC
//   id_rd1/id_rd2  out  XLEN  registered operands rs1/rs2
//   id_ext         out  XLEN  registered immediate
//   id_wr          out  AW    registered rd (if_inst[11:7])
//   perf_stall     out  16    saturating count of load-use stall cycles
// BEHAVIOUR
//   - rs1=if_inst[19:15], rs2=if_inst[24:20], rd=if_inst[11:7] (low AW bits).
//   - Reset (async, rst=1): all RF entries, all id_* outputs, and perf_stall go to 0.
//     Assertion mid-operation drops the in-flight instruction immediately.
//   - RF: written on posedge when wb_we && wb_wr!=0; x0 reads 0 always.
//   - Operand read priority per rs (rs==0 -> 0): EX fwd (HAS_FWD && ex_we && !ex_is_load
//     && ex_wr==rs) > WB write-through (wb_we && wb_wr==rs) > RF array.
//   - Immediate: I {20{i31},i[31:20]}; S {..,i[31:25],i[11:7]}; B {..,i[7],i[30:25],i[11:8],0};
//     U {i[31:12],12'b0}; J {..,i[19:12],i[20],i[30:21],0}; sign bit i[31]; widened to XLEN.
//   - hazard = if_valid && ex_we && ex_wr!=0 && (ex_wr==rs1 || ex_wr==rs2)
//     && (ex_is_load || !HAS_FWD). rs2 compared for all formats (conservative).
//   - id_ready = ex_ready && !hazard (combinational).
//   - ID/EX register, per posedge, in priority order:
//       flush              -> id_valid<=0 (beats stall and !ex_ready); payload don't-care
//       !ex_ready          -> hold everything
//       hazard             -> id_valid<=0 (bubble), payload held
//       else               -> id_valid<=if_valid; payload loaded when if_valid
//   - Latency: instruction accepted at edge N appears on id_* after edge N (1 cycle).
//   - perf_stall += 1 on each edge with hazard && ex_ready && !flush; saturates at 0xFFFF.
//   - Simultaneous WB write and ID read of same reg: read returns the new wb_wd.
// TESTING
//   1. Reset: preload x5=0x1234, pulse rst mid-stream -> id_valid=0 at once; later read x5=0.
//   2. Write-through: wb_we=1,wb_wr=5,wb_wd=0xDEADBEEF with if_inst rs1=5 -> id_rd1=0xDEADBEEF.
//   3. Forward priority: ex_we,ex_wr=6,ex_wd=0x11 (non-load) and wb writes x6=0x22,
//      inst rs2=6 -> id_rd2=0x11; with HAS_FWD=0 -> id_ready=0 one cycle, then id_rd2=0x11 via WB.
//   4. Load-use: ex_is_load,ex_wr=7, inst rs1=7 -> id_ready=0, next id_valid=0, perf_stall=1;
//      hazard cleared next cycle -> instruction issues with id_valid=1.
//   5. Flush: flush=1 while ex_ready=0 and hazard=1 -> id_valid=0 after edge; perf_stall unchanged.
//   6. x0/SEXT: wb writes x0=0xFFFFFFFF -> rs1=0 reads 0; inst 0xFFF00093, sext_op=0 -> id_ext=0xFFFFFFFF.

Source files
------------

// File: rtl/id_stage_pipe.sv
// -----------------------------------------------------------------------------
// id_stage_pipe
//   Instruction-decode stage of the RV32I pipeline. It holds the register file,
//   builds the sign-extended immediate, forwards EX/WB results into the operand
//   read, detects load-use (or any EX-destination, when forwarding is disabled)
//   hazards, and registers the decoded instruction into the ID/EX register
//   with a valid/ready handshake toward IF and EX.
//
// Ports
//   clk, rst            clock (posedge) and asynchronous active-high reset
//   if_valid/if_inst    instruction offered by IF, with its PC on if_pc
//   id_ready            ID accepts the offered instruction this cycle
//   sext_op             immediate format: 0 I, 1 S, 2 B, 3 U, 4 J, others as I
//   flush               kill the ID/EX contents (redirect)
//   ex_ready            EX accepts the ID/EX register this cycle
//   ex_we/ex_wr/ex_wd   destination write of the instruction now in EX
//   ex_is_load          that EX result comes from memory and is not yet known
//   wb_we/wb_wr/wb_wd   register-file write port driven by WB
//   id_valid, id_pc, id_rd1, id_rd2, id_ext, id_wr   ID/EX register contents
//   perf_stall          saturating count of hazard stall cycles
// -----------------------------------------------------------------------------
module id_stage_pipe #(
    parameter int XLEN    = 32,
    parameter int NREG    = 32,
    parameter bit HAS_FWD = 1'b1,
    localparam int AW     = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [31:0]     if_inst,
    input  logic [XLEN-1:0] if_pc,
    output logic            id_ready,
    input  logic [2:0]      sext_op,
    input  logic            flush,
    input  logic            ex_ready,
    input  logic            ex_we,
    input  logic [AW-1:0]   ex_wr,
    input  logic [XLEN-1:0] ex_wd,
    input  logic            ex_is_load,
    input  logic            wb_we,
    input  logic [AW-1:0]   wb_wr,
    input  logic [XLEN-1:0] wb_wd,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_rd1,
    output logic [XLEN-1:0] id_rd2,
    output logic [XLEN-1:0] id_ext,
    output logic [AW-1:0]   id_wr,
    output logic [15:0]     perf_stall
);

    logic [XLEN-1:0]   rf_r [NREG];
    logic [AW-1:0]     rs1_s;
    logic [AW-1:0]     rs2_s;
    logic [AW-1:0]     rd_s;
    logic [XLEN-1:0]   op1_s;
    logic [XLEN-1:0]   op2_s;
    logic signed [31:0] imm32_s;
    logic [XLEN-1:0]   ext_s;
    logic              hazard_s;

    assign rs1_s = if_inst[15 +: AW];
    assign rs2_s = if_inst[20 +: AW];
    assign rd_s  = if_inst[7 +: AW];

    // Operand source priority: x0, then the EX result (only when it is an ALU
    // result), then the value WB is writing this very cycle, then the array.
    function automatic logic [XLEN-1:0] read_operand(input logic [AW-1:0] rs);
        logic [XLEN-1:0] v;
        if (rs == '0) begin
            v = '0;
        end else if (HAS_FWD && ex_we && !ex_is_load && (ex_wr == rs)) begin
            v = ex_wd;
        end else if (wb_we && (wb_wr == rs)) begin
            v = wb_wd;
        end else begin
            v = rf_r[rs];
        end
        return v;
    endfunction

    // Operand read for both source registers.
    always_comb begin
        op1_s = read_operand(rs1_s);
        op2_s = read_operand(rs2_s);
    end

    // Immediate extraction; unused format codes fall back to the I layout.
    always_comb begin
        imm32_s = '0;
        case (sext_op)
            3'd0:    imm32_s = {{20{if_inst[31]}}, if_inst[31:20]};
            3'd1:    imm32_s = {{20{if_inst[31]}}, if_inst[31:25], if_inst[11:7]};
            3'd2:    imm32_s = {{19{if_inst[31]}}, if_inst[31], if_inst[7],
                                if_inst[30:25], if_inst[11:8], 1'b0};
            3'd3:    imm32_s = {if_inst[31:12], 12'd0};
            3'd4:    imm32_s = {{11{if_inst[31]}}, if_inst[31], if_inst[19:12],
                                if_inst[20], if_inst[30:21], 1'b0};
            default: imm32_s = {{20{if_inst[31]}}, if_inst[31:20]};
        endcase
        ext_s = XLEN'(imm32_s);
    end

    // Hazard: EX writes a register we read and its value cannot be forwarded.
    // rs2 is compared regardless of format, which may add harmless stalls.
    always_comb begin
        if (if_valid && ex_we && (ex_wr != '0) && ((ex_wr == rs1_s) || (ex_wr == rs2_s))
            && (ex_is_load || !HAS_FWD)) begin
            hazard_s = 1'b1;
        end else begin
            hazard_s = 1'b0;
        end
        id_ready = ex_ready && !hazard_s;
    end

    // Register file write port; x0 is never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf_r[i] <= '0;
            end
        end else if (wb_we && (wb_wr != '0)) begin
            rf_r[wb_wr] <= wb_wd;
        end
    end

    // ID/EX register: flush beats a stalled EX, which beats a hazard bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid <= 1'b0;
            id_pc    <= '0;
            id_rd1   <= '0;
            id_rd2   <= '0;
            id_ext   <= '0;
            id_wr    <= '0;
        end else if (flush) begin
            id_valid <= 1'b0;
        end else if (!ex_ready) begin
            id_valid <= id_valid;
        end else if (hazard_s) begin
            id_valid <= 1'b0;
        end else begin
            id_valid <= if_valid;
            if (if_valid) begin
                id_pc  <= if_pc;
                id_rd1 <= op1_s;
                id_rd2 <= op2_s;
                id_ext <= ext_s;
                id_wr  <= rd_s;
            end
        end
    end

    // Stall counter: counts only cycles where the hazard alone blocks issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall <= 16'd0;
        end else if (hazard_s && ex_ready && !flush && (perf_stall != 16'hFFFF)) begin
            perf_stall <= perf_stall + 16'd1;
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: two instances (index 1 forwards, index 0 does not)
// share one input stream and are compared every cycle against a behavioural
// model; directed steps pin the model with hand-computed literals.
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic [2:0]  sext_op;
    logic        flush;
    logic        ex_ready;
    logic        ex_we;
    logic [4:0]  ex_wr;
    logic [31:0] ex_wd;
    logic        ex_is_load;
    logic        wb_we;
    logic [4:0]  wb_wr;
    logic [31:0] wb_wd;

    logic        o_ready [2];
    logic        o_valid [2];
    logic [31:0] o_pc    [2];
    logic [31:0] o_rd1   [2];
    logic [31:0] o_rd2   [2];
    logic [31:0] o_ext   [2];
    logic [4:0]  o_wr    [2];
    logic [15:0] o_perf  [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    id_stage_pipe #(.XLEN(32), .NREG(32), .HAS_FWD(1'b1)) dut_fwd (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
        .id_ready(o_ready[1]), .sext_op(sext_op), .flush(flush), .ex_ready(ex_ready),
        .ex_we(ex_we), .ex_wr(ex_wr), .ex_wd(ex_wd), .ex_is_load(ex_is_load),
        .wb_we(wb_we), .wb_wr(wb_wr), .wb_wd(wb_wd), .id_valid(o_valid[1]),
        .id_pc(o_pc[1]), .id_rd1(o_rd1[1]), .id_rd2(o_rd2[1]), .id_ext(o_ext[1]),
        .id_wr(o_wr[1]), .perf_stall(o_perf[1])
    );

    id_stage_pipe #(.XLEN(32), .NREG(32), .HAS_FWD(1'b0)) dut_nofwd (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
        .id_ready(o_ready[0]), .sext_op(sext_op), .flush(flush), .ex_ready(ex_ready),
        .ex_we(ex_we), .ex_wr(ex_wr), .ex_wd(ex_wd), .ex_is_load(ex_is_load),
        .wb_we(wb_we), .wb_wr(wb_wr), .wb_wd(wb_wd), .id_valid(o_valid[0]),
        .id_pc(o_pc[0]), .id_rd1(o_rd1[0]), .id_rd2(o_rd2[0]), .id_ext(o_ext[0]),
        .id_wr(o_wr[0]), .perf_stall(o_perf[0])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_rf    [32];
    logic        m_valid [2];
    logic [31:0] m_pc    [2];
    logic [31:0] m_rd1   [2];
    logic [31:0] m_rd2   [2];
    logic [31:0] m_ext   [2];
    logic [4:0]  m_wr    [2];
    logic [15:0] m_perf  [2];

    // Immediate by shifting the scattered fields to the top and shifting back arithmetically.
    function automatic logic [31:0] imm_of(input logic [31:0] i, input logic [2:0] op);
        logic signed [31:0] t;
        case (op)
            3'd1:    begin t = {i[31:25], i[11:7], 20'd0}; t = t >>> 20; end
            3'd2:    begin t = {i[31], i[7], i[30:25], i[11:8], 1'b0, 19'd0}; t = t >>> 19; end
            3'd3:    t = {i[31:12], 12'd0};
            3'd4:    begin t = {i[31], i[19:12], i[20], i[30:21], 1'b0, 11'd0}; t = t >>> 11; end
            default: begin t = {i[31:20], 20'd0}; t = t >>> 20; end
        endcase
        return t;
    endfunction

    function automatic logic haz(input int f);
        logic [4:0] a;
        logic [4:0] b;
        a = if_inst[19:15];
        b = if_inst[24:20];
        return if_valid && ex_we && (ex_wr != 5'd0) && (ex_wr == a || ex_wr == b)
               && (ex_is_load || f == 0);
    endfunction

    function automatic logic [31:0] op(input int f, input logic [4:0] rs);
        if (rs == 5'd0) return 32'd0;
        if (f == 1 && ex_we && !ex_is_load && ex_wr == rs) return ex_wd;
        if (wb_we && wb_wr == rs) return wb_wd;
        return m_rf[rs];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int f = 0; f < 2; f++) begin
                m_valid[f] <= 1'b0;
                m_pc[f]    <= 32'd0;
                m_rd1[f]   <= 32'd0;
                m_rd2[f]   <= 32'd0;
                m_ext[f]   <= 32'd0;
                m_wr[f]    <= 5'd0;
                m_perf[f]  <= 16'd0;
            end
            for (int r = 0; r < 32; r++) m_rf[r] <= 32'd0;
        end else begin
            for (int f = 0; f < 2; f++) begin
                if (flush) m_valid[f] <= 1'b0;
                else if (!ex_ready) begin end
                else if (haz(f)) m_valid[f] <= 1'b0;
                else begin
                    m_valid[f] <= if_valid;
                    if (if_valid) begin
                        m_pc[f]  <= if_pc;
                        m_rd1[f] <= op(f, if_inst[19:15]);
                        m_rd2[f] <= op(f, if_inst[24:20]);
                        m_ext[f] <= imm_of(if_inst, sext_op);
                        m_wr[f]  <= if_inst[11:7];
                    end
                end
                if (haz(f) && ex_ready && !flush && m_perf[f] != 16'hFFFF)
                    m_perf[f] <= m_perf[f] + 16'd1;
            end
            if (wb_we && wb_wr != 5'd0) m_rf[wb_wr] <= wb_wd;
        end
    end

    // Compare process: away from the active edge, every cycle out of reset.
    always @(negedge clk) begin
        if (!rst) begin
            for (int f = 0; f < 2; f++) begin
                chk($sformatf("id_valid[%0d]", f), {31'd0, o_valid[f]}, {31'd0, m_valid[f]});
                chk($sformatf("id_ready[%0d]", f), {31'd0, o_ready[f]}, {31'd0, ex_ready && !haz(f)});
                chk($sformatf("perf_stall[%0d]", f), {16'd0, o_perf[f]}, {16'd0, m_perf[f]});
                if (m_valid[f]) begin
                    chk($sformatf("id_pc[%0d]", f), o_pc[f], m_pc[f]);
                    chk($sformatf("id_rd1[%0d]", f), o_rd1[f], m_rd1[f]);
                    chk($sformatf("id_rd2[%0d]", f), o_rd2[f], m_rd2[f]);
                    chk($sformatf("id_ext[%0d]", f), o_ext[f], m_ext[f]);
                    chk($sformatf("id_wr[%0d]", f), {27'd0, o_wr[f]}, {27'd0, m_wr[f]});
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_valid   = 1'b0;
        sext_op    = 3'd0;
        flush      = 1'b0;
        ex_ready   = 1'b1;
        ex_we      = 1'b0;
        ex_is_load = 1'b0;
        wb_we      = 1'b0;
    endtask

    function automatic logic [31:0] mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [4:0] rd);
        return {7'd0, rs2, rs1, 3'd0, rd, 7'h33};
    endfunction

    initial begin
        logic [31:0] inst;
        rst = 1'b1;
        idle();
        if_inst = 32'd0; if_pc = 32'd0; ex_wr = 5'd0; ex_wd = 32'd0;
        wb_wr = 5'd0; wb_wd = 32'd0;
        step(); step();
        chk("reset id_valid", {31'd0, o_valid[1]}, 32'd0);
        chk("reset perf", {16'd0, o_perf[1]}, 32'd0);
        chk("reset id_rd1", o_rd1[1], 32'd0);
        rst = 1'b0;

        // preload x5, read it back, then reset mid-stream
        wb_we = 1'b1; wb_wr = 5'd5; wb_wd = 32'h1234;
        step();
        wb_we = 1'b0; if_valid = 1'b1; if_inst = mk(5'd5, 5'd0, 5'd1); if_pc = 32'h100;
        step();
        chk("preload rd1", o_rd1[1], 32'h1234);
        chk("preload valid", {31'd0, o_valid[1]}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async rst valid f", {31'd0, o_valid[1]}, 32'd0);
        chk("async rst valid n", {31'd0, o_valid[0]}, 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("x5 after reset", o_rd1[1], 32'd0);

        // WB write-through
        wb_we = 1'b1; wb_wr = 5'd5; wb_wd = 32'hDEADBEEF; if_inst = mk(5'd5, 5'd0, 5'd2);
        step();
        chk("wt rd1 f", o_rd1[1], 32'hDEADBEEF);
        chk("wt rd1 n", o_rd1[0], 32'hDEADBEEF);

        // EX forward beats WB; no-forward instance stalls, then reads via WB
        ex_we = 1'b1; ex_wr = 5'd6; ex_wd = 32'h11; ex_is_load = 1'b0;
        wb_we = 1'b1; wb_wr = 5'd6; wb_wd = 32'h22; if_inst = mk(5'd0, 5'd6, 5'd3);
        #1;
        chk("fwd ready f", {31'd0, o_ready[1]}, 32'd1);
        chk("fwd ready n", {31'd0, o_ready[0]}, 32'd0);
        step();
        chk("fwd rd2 f", o_rd2[1], 32'h11);
        chk("fwd valid n", {31'd0, o_valid[0]}, 32'd0);
        ex_we = 1'b0; wb_wd = 32'h11;
        step();
        chk("wb rd2 n", o_rd2[0], 32'h11);
        chk("wb valid n", {31'd0, o_valid[0]}, 32'd1);
        wb_we = 1'b0;

        // load-use
        ex_we = 1'b1; ex_is_load = 1'b1; ex_wr = 5'd7; if_inst = mk(5'd7, 5'd0, 5'd4);
        #1;
        chk("lu ready f", {31'd0, o_ready[1]}, 32'd0);
        step();
        chk("lu bubble f", {31'd0, o_valid[1]}, 32'd0);
        chk("lu perf f", {16'd0, o_perf[1]}, 32'd1);
        chk("lu perf n", {16'd0, o_perf[0]}, 32'd2);
        ex_we = 1'b0; ex_is_load = 1'b0;
        step();
        chk("lu issue f", {31'd0, o_valid[1]}, 32'd1);

        // flush beats !ex_ready and hazard
        flush = 1'b1; ex_ready = 1'b0; ex_we = 1'b1; ex_is_load = 1'b1;
        step();
        chk("flush valid f", {31'd0, o_valid[1]}, 32'd0);
        chk("flush perf f", {16'd0, o_perf[1]}, 32'd1);
        chk("flush perf n", {16'd0, o_perf[0]}, 32'd2);
        idle();

        // x0 and immediates
        if_valid = 1'b1; wb_we = 1'b1; wb_wr = 5'd0; wb_wd = 32'hFFFFFFFF;
        if_inst = 32'hFFF00093; sext_op = 3'd0;
        step();
        chk("x0 rd1", o_rd1[1], 32'd0);
        chk("I ext", o_ext[1], 32'hFFFFFFFF);
        chk("I wr", {27'd0, o_wr[1]}, 32'd1);
        wb_we = 1'b0; if_inst = 32'h12345037; sext_op = 3'd3;
        step();
        chk("U ext", o_ext[1], 32'h12345000);
        if_inst = 32'hFE000FE3; sext_op = 3'd2;
        step();
        chk("B ext", o_ext[1], 32'hFFFFFFFE);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            inst = $urandom;
            inst[19:15] = 5'($urandom_range(7, 0));
            inst[24:20] = 5'($urandom_range(7, 0));
            inst[11:7]  = 5'($urandom_range(7, 0));
            if_inst    = inst;
            if_valid   = ($urandom_range(3, 0) != 0);
            if_pc      = $urandom;
            sext_op    = 3'($urandom_range(7, 0));
            flush      = ($urandom_range(15, 0) == 0);
            ex_ready   = ($urandom_range(7, 0) != 0);
            ex_we      = 1'($urandom_range(1, 0));
            ex_wr      = 5'($urandom_range(7, 0));
            ex_wd      = $urandom;
            ex_is_load = ($urandom_range(2, 0) == 0);
            wb_we      = 1'($urandom_range(1, 0));
            wb_wr      = 5'($urandom_range(7, 0));
            wb_wd      = $urandom;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
